// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, tick-sampled debounce FSM per button, priority key encoder
module btn_debounce #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 3,
    parameter int CODE_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N_BTN-1:0]  btn_in,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    output logic [N_BTN-1:0]  btn_release,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code
);
    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
    localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);
    logic [N_BTN-1:0] meta, sync;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= btn_in;
            sync <= meta;
        end
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t     st, st_n;
        logic [3:0] cnt, cnt_n;
        logic       lvl, lvl_n, prs, prs_n, rel, rel_n;
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= RELEASED;
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rel <= 1'b0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                lvl <= lvl_n;
                prs <= prs_n;
                rel <= rel_n;
            end
        end
        // pulses default low so they last exactly one clk whatever tick does
        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            lvl_n = lvl;
            prs_n = 1'b0;
            rel_n = 1'b0;
            if (tick) begin
                case (st)
                    RELEASED:
                        if (sync[i]) begin
                            st_n  = PRESS_CHK;
                            cnt_n = 4'd1;
                        end
                    PRESS_CHK:
                        if (!sync[i]) begin
                            st_n  = RELEASED;
                            cnt_n = 4'd0;
                        end else if (cnt == LAST) begin
                            st_n  = PRESSED;
                            cnt_n = 4'd0;
                            lvl_n = 1'b1;
                            prs_n = 1'b1;
                        end else cnt_n = cnt + 4'd1;
                    PRESSED:
                        if (!sync[i]) begin
                            st_n  = RELEASE_CHK;
                            cnt_n = 4'd1;
                        end
                    RELEASE_CHK:
                        if (sync[i]) begin
                            st_n  = PRESSED;
                            cnt_n = 4'd0;
                        end else if (cnt == LAST) begin
                            st_n  = RELEASED;
                            cnt_n = 4'd0;
                            lvl_n = 1'b0;
                            rel_n = 1'b1;
                        end else cnt_n = cnt + 4'd1;
                endcase
            end
        end
        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rel;
    end
    assign key_valid = |btn_press;
    always_comb begin
        key_code = '0;
        for (int j = N_BTN - 1; j >= 0; j--)
            if (btn_press[j]) key_code = CODE_W'(j);
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed scenarios with hand-computed pulse cycles, tick every 8 clks
module tb_btn_debounce;
    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [3:0] btn_in = 4'b0000;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       key_valid;
    logic [1:0] key_code;
    btn_debounce #(.N_BTN(4), .STABLE_TICKS(3), .CODE_W(2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .key_valid(key_valid), .key_code(key_code)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    logic tick_en = 1'b1;
    int np, nr, nv, kv_bad, p_cyc, r_cyc;
    logic [3:0] p_val, r_val, any_out;
    logic [1:0] p_code;
    logic       p_kv;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic clr();
        np = 0; nr = 0; nv = 0; kv_bad = 0; p_cyc = -1; r_cyc = -1;
        p_val = '0; r_val = '0; p_code = '0; p_kv = 1'b0; any_out = '0;
    endtask
    // sample outputs of the previous posedge, then drive this cycle's tick
    task automatic step();
        @(negedge clk);
        cyc++;
        if (btn_press != 0) begin
            np++; p_val = btn_press; p_cyc = cyc; p_code = key_code; p_kv = key_valid;
        end
        if (btn_release != 0) begin
            nr++; r_val = btn_release; r_cyc = cyc;
        end
        if (key_valid) nv++;
        if (key_valid !== (btn_press != 0)) kv_bad++;
        if (btn_press == 0 && key_code != 0) kv_bad++;
        any_out = any_out | btn_level | btn_press | btn_release | {3'b000, key_valid} | {2'b00, key_code};
        tick = tick_en && (cyc % 8 == 0);
    endtask
    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask
    initial begin
        clr();
        run_to(4);
        check("reset_outputs", {btn_level, btn_press, btn_release, key_valid, key_code}, 0);
        rst = 1'b0;
        run_to(100);
        clr();
        btn_in = 4'b0100;
        run_to(160);
        check("press_count", np, 1);
        check("press_value", p_val, 4'b0100);
        check("press_cycle", p_cyc, 121);
        check("press_code", p_code, 2);
        check("press_valid", p_kv, 1);
        check("press_level", btn_level, 4'b0100);
        check("press_kv_consistent", kv_bad, 0);
        clr();
        btn_in = 4'b0000;
        run_to(220);
        check("release_count", nr, 1);
        check("release_value", r_val, 4'b0100);
        check("release_cycle", r_cyc, 185);
        check("release_no_valid", nv, 0);
        check("release_level", btn_level, 0);
        clr();
        btn_in = 4'b0001;
        run_to(236);
        btn_in = 4'b0000;
        run_to(244);
        btn_in = 4'b0001;
        run_to(280);
        check("bounce_count", np, 1);
        check("bounce_cycle", p_cyc, 265);
        check("bounce_value", p_val, 4'b0001);
        btn_in = 4'b0000;
        run_to(320);
        check("bounce_release_level", btn_level, 0);
        clr();
        btn_in = 4'b1010;
        run_to(360);
        check("simul_count", np, 1);
        check("simul_value", p_val, 4'b1010);
        check("simul_cycle", p_cyc, 345);
        check("simul_code", p_code, 1);
        check("simul_valid", p_kv, 1);
        check("simul_level", btn_level, 4'b1010);
        btn_in = 4'b0000;
        run_to(400);
        check("simul_release_count", nr, 1);
        check("simul_release_level", btn_level, 0);
        clr();
        tick_en = 1'b0;
        btn_in = 4'b1111;
        run_to(600);
        btn_in = 4'b0000;
        run_to(608);
        tick_en = 1'b1;
        run_to(640);
        check("starve_outputs", any_out, 0);
        clr();
        btn_in = 4'b1000;
        run_to(658);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_outputs", {btn_level, btn_press, btn_release, key_valid, key_code}, 0);
        run_to(700);
        check("midreset_count", np, 1);
        check("midreset_cycle", p_cyc, 681);
        check("midreset_value", p_val, 4'b1000);
        check("midreset_code", p_code, 3);
        check("midreset_kv_consistent", kv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
